// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN output-stage decoder.
package snn_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} dec_state_t;

   // Index width that stays at least one bit even for a single-entry array.
   function automatic int clog2_min1(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of per-neuron saturating spike counters with a single indexed read port.
module spike_counter_bank
   import snn_pkg::*;
#(
   parameter int N_NEURONS = 8,
   parameter int CNT_W     = 8,
   parameter int IDX_W     = clog2_min1(N_NEURONS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             inc_en_i,
   input  logic             spikes_i [N_NEURONS],
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [CNT_W-1:0] rd_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q [N_NEURONS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
      end else if (inc_en_i) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            if (spikes_i[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/spike_count_decoder.sv
// Spike-count window decoder with sequential argmax and valid/ready result hold.
// Optional tie flag output enabled by defining SPIKE_DEC_TIE_EN.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | counting spikes over WINDOW valid timesteps
// SCAN  | one counter per cycle, tracking the lowest-index maximum
// DONE  | result held until the host handshake
module spike_count_decoder
   import snn_pkg::*;
#(
   parameter int N_NEURONS = 8,
   parameter int WINDOW    = 64,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 step_valid,
   input  logic                 spikes_in [N_NEURONS],
   output logic                 busy,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic [clog2_min1(N_NEURONS)-1:0] class_idx,
   output logic [CNT_W-1:0]     class_count
`ifdef SPIKE_DEC_TIE_EN
   ,
   output logic                 tie
`endif
);

   localparam int IDX_W = clog2_min1(N_NEURONS);
   localparam int SC_W  = $clog2(WINDOW + 1);
   localparam logic [SC_W-1:0]  LAST_STEP = SC_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] LAST_J    = IDX_W'(N_NEURONS - 1);

   dec_state_t       state_q, state_d;
   logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
   logic [IDX_W-1:0] scan_j_q, scan_j_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
   logic [CNT_W-1:0] rd_cnt;
   logic             clear, inc_en;
`ifdef SPIKE_DEC_TIE_EN
   logic             tie_q, tie_d;
`endif

   spike_counter_bank #(
      .N_NEURONS (N_NEURONS),
      .CNT_W     (CNT_W),
      .IDX_W     (IDX_W)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (clear),
      .inc_en_i (inc_en),
      .spikes_i (spikes_in),
      .rd_idx_i (scan_j_q),
      .rd_cnt_o (rd_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         step_cnt_q <= '0;
         scan_j_q   <= '0;
         best_idx_q <= '0;
         best_cnt_q <= '0;
`ifdef SPIKE_DEC_TIE_EN
         tie_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         step_cnt_q <= step_cnt_d;
         scan_j_q   <= scan_j_d;
         best_idx_q <= best_idx_d;
         best_cnt_q <= best_cnt_d;
`ifdef SPIKE_DEC_TIE_EN
         tie_q      <= tie_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      scan_j_d   = scan_j_q;
      best_idx_d = best_idx_q;
      best_cnt_d = best_cnt_q;
      clear      = 1'b0;
      inc_en     = 1'b0;
`ifdef SPIKE_DEC_TIE_EN
      tie_d      = tie_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               clear      = 1'b1;
               step_cnt_d = '0;
               state_d    = ACCUM;
            end
         end
         ACCUM: begin
            if (step_valid) begin
               inc_en     = 1'b1;
               step_cnt_d = step_cnt_q + SC_W'(1);
               if (step_cnt_q == LAST_STEP) begin
                  state_d  = SCAN;
                  scan_j_d = '0;
               end
            end
         end
         SCAN: begin
            // Strict compare keeps the earliest index on equal counts.
            if (scan_j_q == '0) begin
               best_cnt_d = rd_cnt;
               best_idx_d = '0;
`ifdef SPIKE_DEC_TIE_EN
               tie_d      = 1'b0;
`endif
            end else if (rd_cnt > best_cnt_q) begin
               best_cnt_d = rd_cnt;
               best_idx_d = scan_j_q;
`ifdef SPIKE_DEC_TIE_EN
               tie_d      = 1'b0;
`endif
            end else if (rd_cnt == best_cnt_q) begin
`ifdef SPIKE_DEC_TIE_EN
               tie_d      = 1'b1;
`endif
            end
            if (scan_j_q == LAST_J) state_d = DONE;
            else                    scan_j_d = scan_j_q + IDX_W'(1);
         end
         DONE: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy         = (state_q == ACCUM) || (state_q == SCAN);
   assign result_valid = (state_q == DONE);
   assign class_idx    = best_idx_q;
   assign class_count  = best_cnt_q;
`ifdef SPIKE_DEC_TIE_EN
   assign tie          = tie_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_spike_count_decoder.sv
// Self-checking bench: two decoders (CNT_W=8 and CNT_W=4) driven with identical windows.
module tb_spike_count_decoder;

   localparam int N = 8;
   localparam int W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, step_valid, result_ready;
   logic spikes_in [N];
   logic busy_a, rv_a, busy_b, rv_b;
   logic [2:0] idx_a, idx_b;
   logic [7:0] cnt_a;
   logic [3:0] cnt_b;
`ifdef SPIKE_DEC_TIE_EN
   logic tie_a, tie_b;
`endif

   spike_count_decoder #(.N_NEURONS(N), .WINDOW(W), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .step_valid(step_valid), .spikes_in(spikes_in),
      .busy(busy_a), .result_valid(rv_a), .result_ready(result_ready),
      .class_idx(idx_a), .class_count(cnt_a)
`ifdef SPIKE_DEC_TIE_EN
      , .tie(tie_a)
`endif
   );

   spike_count_decoder #(.N_NEURONS(N), .WINDOW(W), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .start(start), .step_valid(step_valid), .spikes_in(spikes_in),
      .busy(busy_b), .result_valid(rv_b), .result_ready(result_ready),
      .class_idx(idx_b), .class_count(cnt_b)
`ifdef SPIKE_DEC_TIE_EN
      , .tie(tie_b)
`endif
   );

   typedef struct {
      int rate [N];
      bit gaps;
      int hold;
      int e_idx8, e_cnt8, e_idx4, e_cnt4;
      bit e_tie8, e_tie4;
   } vec_t;

   vec_t       tbl [5];
   logic [7:0] step_spk [W];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_spikes(input logic [7:0] v);
      for (int i = 0; i < N; i++) spikes_in[i] = v[i];
   endtask

   task automatic load_rates(input vec_t v);
      for (int s = 0; s < W; s++)
         for (int i = 0; i < N; i++) step_spk[s][i] = (s < v.rate[i]);
   endtask

   // Reference: per-neuron totals clipped to the counter range, lowest-index maximum.
   task automatic model(input int cw, output int idx, output int cnt, output bit tie);
      int c [N];
      int mx, nmax, lim;
      lim = (1 << cw) - 1;
      mx  = 0;
      for (int i = 0; i < N; i++) begin
         c[i] = 0;
         for (int s = 0; s < W; s++) c[i] += int'(step_spk[s][i]);
         if (c[i] > lim) c[i] = lim;
         if (c[i] > mx) mx = c[i];
      end
      idx  = -1;
      nmax = 0;
      for (int i = 0; i < N; i++) begin
         if (c[i] == mx) begin
            nmax++;
            if (idx < 0) idx = i;
         end
      end
      cnt = mx;
      tie = (nmax > 1);
   endtask

   task automatic window(input string tag, input vec_t v);
      int  lat;
      bit  stable;
      logic [2:0] hidx;
      logic [7:0] hcnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check({tag, " busy in ACCUM"}, int'(busy_a), 1);
      for (int s = 0; s < W; s++) begin
         if (v.gaps) begin
            repeat ($urandom_range(0, 2)) begin
               step_valid = 1'b0;
               set_spikes(8'($urandom));
               @(negedge clk);
            end
         end
         step_valid = 1'b1;
         set_spikes(step_spk[s]);
         @(negedge clk);
      end
      // Junk during SCAN must be dropped.
      step_valid = 1'b1;
      set_spikes(8'($urandom));
      lat = 1;
      while (!rv_a && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      step_valid = 1'b0;
      check({tag, " latency"}, lat, 9);
      check({tag, " rv_b"}, int'(rv_b), 1);
      check({tag, " idx8"}, int'(idx_a), v.e_idx8);
      check({tag, " cnt8"}, int'(cnt_a), v.e_cnt8);
      check({tag, " idx4"}, int'(idx_b), v.e_idx4);
      check({tag, " cnt4"}, int'(cnt_b), v.e_cnt4);
`ifdef SPIKE_DEC_TIE_EN
      check({tag, " tie8"}, int'(tie_a), int'(v.e_tie8));
      check({tag, " tie4"}, int'(tie_b), int'(v.e_tie4));
`endif
      hidx   = idx_a;
      hcnt   = cnt_a;
      stable = 1'b1;
      result_ready = 1'b0;
      for (int k = 0; k < v.hold; k++) begin
         start = k[0];
         @(negedge clk);
         if (!rv_a || busy_a || idx_a !== hidx || cnt_a !== hcnt) stable = 1'b0;
      end
      if (v.hold > 0) check({tag, " hold stable"}, int'(stable), 1);
      result_ready = 1'b1;
      start        = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      start        = 1'b0;
      check({tag, " rv after handshake"}, int'(rv_a), 0);
      check({tag, " start ignored at handshake"}, int'(busy_a), 0);
`ifdef SPIKE_DEC_TIE_EN
      check({tag, " tie 0 outside DONE"}, int'(tie_b), 0);
`endif
   endtask

   initial begin
      vec_t v;
      bit   saw_rv;
      rst = 1'b0; start = 1'b0; step_valid = 1'b0; result_ready = 1'b0;
      set_spikes(8'h00);

      tbl[0].rate = '{0,0,0,0,0,64,0,0};  tbl[0].gaps = 0; tbl[0].hold = 20;
      tbl[0].e_idx8 = 5; tbl[0].e_cnt8 = 64; tbl[0].e_idx4 = 5; tbl[0].e_cnt4 = 15;
      tbl[0].e_tie8 = 0; tbl[0].e_tie4 = 0;
      tbl[1].rate = '{3,3,10,3,3,3,10,3}; tbl[1].gaps = 1; tbl[1].hold = 2;
      tbl[1].e_idx8 = 2; tbl[1].e_cnt8 = 10; tbl[1].e_idx4 = 2; tbl[1].e_cnt4 = 10;
      tbl[1].e_tie8 = 1; tbl[1].e_tie4 = 1;
      tbl[2].rate = '{20,64,0,0,0,0,0,0}; tbl[2].gaps = 0; tbl[2].hold = 0;
      tbl[2].e_idx8 = 1; tbl[2].e_cnt8 = 64; tbl[2].e_idx4 = 0; tbl[2].e_cnt4 = 15;
      tbl[2].e_tie8 = 0; tbl[2].e_tie4 = 1;
      tbl[3].rate = '{0,0,0,0,0,0,0,0};   tbl[3].gaps = 1; tbl[3].hold = 3;
      tbl[3].e_idx8 = 0; tbl[3].e_cnt8 = 0; tbl[3].e_idx4 = 0; tbl[3].e_cnt4 = 0;
      tbl[3].e_tie8 = 1; tbl[3].e_tie4 = 1;
      tbl[4].rate = '{0,0,0,39,0,0,0,40}; tbl[4].gaps = 1; tbl[4].hold = 1;
      tbl[4].e_idx8 = 7; tbl[4].e_cnt8 = 40; tbl[4].e_idx4 = 3; tbl[4].e_cnt4 = 15;
      tbl[4].e_tie8 = 0; tbl[4].e_tie4 = 1;

      repeat (2) @(negedge clk);
      check("reset rv", int'(rv_a), 0);
      check("reset busy", int'(busy_a), 0);
      check("reset idx", int'(idx_a), 0);
      check("reset cnt", int'(cnt_a), 0);
      rst = 1'b1;

      for (int t = 0; t < 5; t++) begin
         load_rates(tbl[t]);
         window($sformatf("vec%0d", t), tbl[t]);
      end

      // Reset in the middle of accumulation discards the window.
      load_rates(tbl[0]);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int s = 0; s < 30; s++) begin
         step_valid = 1'b1;
         set_spikes(step_spk[s]);
         @(negedge clk);
      end
      step_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("midreset busy", int'(busy_a), 0);
      check("midreset rv", int'(rv_a), 0);
      check("midreset idx", int'(idx_a), 0);
      check("midreset cnt4", int'(cnt_b), 0);
      @(negedge clk); rst = 1'b1;
      saw_rv = 1'b0;
      repeat (15) begin
         step_valid = 1'b1;
         set_spikes(8'hff);
         @(negedge clk);
         if (rv_a || busy_a) saw_rv = 1'b1;
      end
      step_valid = 1'b0;
      check("no result after reset", int'(saw_rv), 0);
      window("post-reset", tbl[0]);

      for (int r = 0; r < 6; r++) begin
         int p [N];
         for (int i = 0; i < N; i++) p[i] = $urandom_range(0, 100);
         for (int s = 0; s < W; s++)
            for (int i = 0; i < N; i++) step_spk[s][i] = ($urandom_range(0, 99) < p[i]);
         v.gaps = 1'($urandom_range(0, 1));
         v.hold = $urandom_range(0, 4);
         model(8, v.e_idx8, v.e_cnt8, v.e_tie8);
         model(4, v.e_idx4, v.e_cnt4, v.e_tie4);
         window($sformatf("rand%0d", r), v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
